// File: rtl/crack_pkg.sv
// Shared widths and FSM state encoding for the crack scheduler.
package crack_pkg;

    localparam int KEY_W     = 24;
    localparam int CT_ADDR_W = 8;
    localparam int CT_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        ABORT = 2'd3
    } state_t;

endpackage

// File: rtl/crack_sched_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, registered priority pointer.
// After a grant to engine i the highest priority moves to (i+1) mod N.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_reg;
    logic [PW-1:0] ptr_next;
    logic          found;
    int            idx;

    // Scan requests starting at the pointer; first requester wins.
    always_comb begin
        gnt      = '0;
        ptr_next = ptr_reg;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_reg) + k) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                ptr_next = PW'((idx + 1) % N);
            end
        end
    end

    // Pointer only advances on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/crack_sched.sv
// Crack scheduler: starts NCORE engines together, collects the first valid key,
// aborts the rest, and round-robins their shared ciphertext read port.
// Optional feature macro: CRACK_SCHED_STATS_EN adds a saturating run_cycles counter.
module crack_sched
    import crack_pkg::*;
#(
    parameter int NCORE = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    output logic                     rdy,
    output logic [KEY_W-1:0]         key,
    output logic                     key_valid,
    output logic [CT_ADDR_W-1:0]     ct_addr,
    input  logic [CT_DATA_W-1:0]     ct_rddata,
    output logic [NCORE-1:0]         core_en,
    output logic [NCORE-1:0]         core_abort,
    input  logic [NCORE-1:0]         core_rdy,
    input  logic [NCORE*KEY_W-1:0]   core_key,
    input  logic [NCORE-1:0]         core_key_valid,
    input  logic [NCORE-1:0]         core_ct_req,
    input  logic [NCORE*CT_ADDR_W-1:0] core_ct_addr,
    output logic [NCORE-1:0]         core_ct_gnt,
    output logic [CT_DATA_W-1:0]     core_ct_rddata,
    output logic [NCORE-1:0]         core_ct_vld
`ifdef CRACK_SCHED_STATS_EN
    ,
    output logic [31:0]              run_cycles
`endif
);

    localparam int SW = (NCORE > 1) ? $clog2(NCORE) : 1;

    state_t             state_reg;
    logic [KEY_W-1:0]   key_reg;
    logic               key_valid_reg;
    logic [NCORE-1:0]   core_en_reg;
    logic [NCORE-1:0]   core_abort_reg;
    logic [NCORE-1:0]   fin_mask_reg;
    logic [NCORE-1:0]   fin_mask_next;
    logic               first_run_reg;
    logic [NCORE-1:0]   done_now;
    logic [NCORE-1:0]   found;
    logic [SW-1:0]      sel;
    logic [NCORE-1:0]   gnt;
    logic [NCORE-1:0]   ct_vld_reg;
    logic [CT_ADDR_W-1:0] ct_addr_mux;

    logic [KEY_W-1:0]     core_key_arr  [NCORE];
    logic [CT_ADDR_W-1:0] core_addr_arr [NCORE];

    for (genvar gi = 0; gi < NCORE; gi++) begin : g_unpack
        assign core_key_arr[gi]  = core_key[gi*KEY_W +: KEY_W];
        assign core_addr_arr[gi] = core_ct_addr[gi*CT_ADDR_W +: CT_ADDR_W];
    end

    // Engines still look idle while core_en is in flight, so the first RUN
    // cycle is not allowed to mark anything finished.
    always_comb begin
        done_now      = (state_reg == RUN && !first_run_reg) ? core_rdy : '0;
        fin_mask_next = fin_mask_reg | done_now;
        found         = done_now & ~fin_mask_reg & core_key_valid;
    end

    // Lowest-index newly finished engine with a valid key wins.
    always_comb begin
        sel = '0;
        for (int i = NCORE - 1; i >= 0; i--) begin
            if (found[i]) sel = SW'(i);
        end
    end

    // Main sequencing FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            key_reg        <= '0;
            key_valid_reg  <= 1'b0;
            core_en_reg    <= '0;
            core_abort_reg <= '0;
            fin_mask_reg   <= '0;
            first_run_reg  <= 1'b0;
        end else begin
            core_en_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (en) begin
                        key_reg       <= '0;
                        key_valid_reg <= 1'b0;
                        state_reg     <= START;
                    end
                end
                START: begin
                    if (&core_rdy) begin
                        core_en_reg   <= '1;
                        fin_mask_reg  <= '0;
                        first_run_reg <= 1'b1;
                        state_reg     <= RUN;
                    end
                end
                RUN: begin
                    first_run_reg <= 1'b0;
                    fin_mask_reg  <= fin_mask_next;
                    if (|found) begin
                        key_reg        <= core_key_arr[sel];
                        key_valid_reg  <= 1'b1;
                        core_abort_reg <= ~fin_mask_next;
                        state_reg      <= ABORT;
                    end else if (&fin_mask_next) begin
                        key_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                ABORT: begin
                    if (&core_rdy) begin
                        core_abort_reg <= '0;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    rr_arbiter #(.N(NCORE)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (core_ct_req),
        .gnt   (gnt)
    );

    // Address mux driven by the one-hot grant; zero when nobody is granted.
    always_comb begin
        ct_addr_mux = '0;
        for (int i = 0; i < NCORE; i++) begin
            if (gnt[i]) ct_addr_mux = ct_addr_mux | core_addr_arr[i];
        end
    end

    // Read data returns one cycle after grant; flag its owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ct_vld_reg <= '0;
        end else begin
            ct_vld_reg <= gnt;
        end
    end

`ifdef CRACK_SCHED_STATS_EN
    logic [31:0] run_cycles_reg;

    // Saturating RUN-cycle counter, cleared when a new search is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cycles_reg <= '0;
        end else if (state_reg == IDLE && en) begin
            run_cycles_reg <= '0;
        end else if (state_reg == RUN && run_cycles_reg != '1) begin
            run_cycles_reg <= run_cycles_reg + 32'd1;
        end
    end

    assign run_cycles = run_cycles_reg;
`endif

    assign rdy            = (state_reg == IDLE);
    assign key            = key_reg;
    assign key_valid      = key_valid_reg;
    assign core_en        = core_en_reg;
    assign core_abort     = core_abort_reg;
    assign core_ct_gnt    = gnt;
    assign ct_addr        = ct_addr_mux;
    assign core_ct_rddata = ct_rddata;
    assign core_ct_vld    = ct_vld_reg;

endmodule

// File: doc/crack_sched.md
CRACK_SCHED -- requirements
Module: crack_sched

Interface
REQ-001 Parameter: NCORE, default 2, number of crack engines sequenced and sharing one ciphertext read port.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  start request, honoured only while rdy=1.
REQ-005 rdy  output  1  scheduler idle, able to accept en.
REQ-006 key  output  24  recovered key.
REQ-007 key_valid  output  1  key holds a found key.
REQ-008 ct_addr  output  8  address to shared ciphertext memory (1-cycle read latency).
REQ-009 ct_rddata  input  8  ciphertext memory read data.
REQ-010 core_en  output  NCORE  one-cycle start pulse per engine.
REQ-011 core_abort  output  NCORE  level, stop request per engine.
REQ-012 core_rdy  input  NCORE  engine idle.
REQ-013 core_key  input  NCORE x 24  engine result key.
REQ-014 core_key_valid  input  NCORE  engine result valid.
REQ-015 core_ct_req  input  NCORE  engine requests ciphertext read; held until granted.
REQ-016 core_ct_addr  input  NCORE x 8  requested address.
REQ-017 core_ct_gnt  output  NCORE  one-hot grant, combinational, same cycle as req.
REQ-018 core_ct_rddata  output  8  broadcast of ct_rddata.
REQ-019 core_ct_vld  output  NCORE  one-hot, registered, high the cycle after grant: core_ct_rddata valid for that engine.

Function
REQ-020 FSM states IDLE, START, RUN, ABORT; rdy=1 only in IDLE.
REQ-021 IDLE: en=1 -> START; clear key_valid, key=0.
REQ-022 START: wait until core_rdy all 1; then pulse core_en all ones for exactly one cycle and enter RUN.
REQ-023 RUN: an engine counts finished when core_rdy=1 from the second RUN cycle onward; finished bits tracked in a sticky mask.
REQ-024 RUN: first finishing engine with core_key_valid=1 -> key<=core_key, key_valid<=1, enter ABORT; simultaneous finds: lowest index wins.
REQ-025 RUN: all engines finished, none valid -> key_valid=0, enter IDLE.
REQ-026 ABORT: core_abort=1 to all unfinished engines; when core_rdy all 1, deassert core_abort, enter IDLE.
REQ-027 Arbitration: round-robin over core_ct_req, at most one grant per cycle; ct_addr = core_ct_addr of granted engine, else 0.
REQ-028 Pointer: after a grant to i, highest priority moves to (i+1) mod NCORE; no grant -> pointer unchanged.
REQ-029 Grants issued in any state; requests from an engine under core_abort still granted (engine must drain).
REQ-030 en while rdy=0 ignored; key/key_valid stable in IDLE until next accepted en.

Reset
REQ-031 rst_n=0 asynchronously: state IDLE, rdy=1, key=0, key_valid=0, core_en=0, core_abort=0, core_ct_vld=0, pointer=0, finished mask=0.
REQ-032 Reset mid-RUN or mid-ABORT abandons the search with the above values; no core_en pulse on reset release.

Configuration
REQ-033 Macro CRACK_SCHED_STATS_EN: when defined, adds output run_cycles (32 bits), cleared on accepted en, incremented each RUN cycle, saturating at all-ones, reset 0; when undefined, port and counter absent, other behaviour identical.

Structure
REQ-034 Package crack_pkg: KEY_W=24, CT_ADDR_W=8, CT_DATA_W=8, FSM state enum.
REQ-035 Sub-module rr_arbiter (NCORE-wide request/grant, pointer register) instantiated once.

Verification
REQ-036 NCORE=2, en pulse, core 1 finishes with key 24'h00_1A2B valid, core 0 busy -> key=24'h001A2B, key_valid=1, core_abort=2'b01 until core_rdy[0]=1, then rdy=1.
REQ-037 Both cores finish, no valid key -> key_valid=0, rdy=1, core_abort never asserted.
REQ-038 Both cores finish valid same cycle (keys 24'h000010, 24'h000020) -> key=24'h000010.
REQ-039 Both core_ct_req held 4 cycles -> grants alternate 01,10,01,10; ct_addr tracks granted address; core_ct_vld follows one cycle later with ct_rddata broadcast.
REQ-040 rst_n low mid-RUN -> immediately rdy=1, key_valid=0, core_abort=0; en while rdy=0 produces no core_en.
REQ-041 With CRACK_SCHED_STATS_EN, 100-cycle RUN -> run_cycles=100; second en clears to 0.
